// File: rtl/btb_branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters for IF next-PC prediction.
// Optional BTB_BYPASS_EN forwards a same-cycle matching update to the lookup.
module btb_branch_predictor #(
    parameter int ENTRIES  = 8,
    parameter int IDX_BITS = 3,
    parameter int PC_BITS  = 32
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Flush_All,
    input  logic [PC_BITS-1:0] Lookup_PC,
    output logic               Pred_Hit,
    output logic               Pred_Taken,
    output logic [PC_BITS-1:0] Pred_Next_PC,
    input  logic               Upd_Valid,
    input  logic [PC_BITS-1:0] Upd_PC,
    input  logic               Upd_Taken,
    input  logic [PC_BITS-1:0] Upd_Target
);

    localparam int TAG_BITS = PC_BITS - IDX_BITS - 2;

    logic                valid_q  [ENTRIES];
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [PC_BITS-1:0]  target_q [ENTRIES];
    logic [1:0]          ctr_q    [ENTRIES];

    logic [IDX_BITS-1:0] lk_idx;
    logic [TAG_BITS-1:0] lk_tag;
    logic [IDX_BITS-1:0] up_idx;
    logic [TAG_BITS-1:0] up_tag;

    assign lk_idx = Lookup_PC[IDX_BITS+1:2];
    assign lk_tag = Lookup_PC[PC_BITS-1:IDX_BITS+2];
    assign up_idx = Upd_PC[IDX_BITS+1:2];
    assign up_tag = Upd_PC[PC_BITS-1:IDX_BITS+2];

    // Byte-offset bits never take part in indexing or tagging.
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{Lookup_PC[1:0], Upd_PC[1:0]};

    logic               up_hit;
    logic               up_wr;
    logic [1:0]         up_ctr;
    logic [PC_BITS-1:0] up_tgt;

    // Post-update contents of the entry addressed by the resolving branch.
    always_comb begin
        up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
        up_wr  = 1'b0;
        up_ctr = ctr_q[up_idx];
        up_tgt = target_q[up_idx];
        if (up_hit) begin
            up_wr = 1'b1;
            if (Upd_Taken) begin
                up_ctr = (ctr_q[up_idx] == 2'b11) ? 2'b11
                       : ctr_q[up_idx] + 2'b01;
                up_tgt = Upd_Target;
            end else begin
                up_ctr = (ctr_q[up_idx] == 2'b00) ? 2'b00
                       : ctr_q[up_idx] - 2'b01;
            end
        end else if (Upd_Taken) begin
            up_wr  = 1'b1;
            up_ctr = 2'b10;
            up_tgt = Upd_Target;
        end
    end

    logic               ent_hit;
    logic [1:0]         ent_ctr;
    logic [PC_BITS-1:0] ent_tgt;

    // Zero-latency lookup of the entry selected by the fetch PC.
    always_comb begin
        ent_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        ent_ctr = ctr_q[lk_idx];
        ent_tgt = target_q[lk_idx];
`ifdef BTB_BYPASS_EN
        if (Upd_Valid && up_wr && !Reset && !Flush_All &&
            (up_idx == lk_idx) && (up_tag == lk_tag)) begin
            ent_hit = 1'b1;
            ent_ctr = up_ctr;
            ent_tgt = up_tgt;
        end
`endif
    end

    assign Pred_Hit     = ent_hit;
    assign Pred_Taken   = ent_hit & ent_ctr[1];
    assign Pred_Next_PC = Pred_Taken ? ent_tgt
                        : Lookup_PC + PC_BITS'(4);

    // Reset and flush invalidate everything; otherwise train one entry.
    always_ff @(posedge Clock) begin
        if (Reset || Flush_All) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= 2'b00;
            end
        end else if (Upd_Valid && up_wr) begin
            valid_q[up_idx]  <= 1'b1;
            tag_q[up_idx]    <= up_tag;
            target_q[up_idx] <= up_tgt;
            ctr_q[up_idx]    <= up_ctr;
        end
    end

endmodule

// File: tb/tb_btb_branch_predictor.sv
// Bench for btb_branch_predictor: reference model plus directed literals.
// Honors BTB_BYPASS_EN the same way the design build does.
module tb_btb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [31:0] lpc = 32'h0;
    logic        hit;
    logic        taken;
    logic [31:0] npc;
    logic        uv = 1'b0;
    logic [31:0] upc = 32'h0;
    logic        ut = 1'b0;
    logic [31:0] utg = 32'h0;

    int total = 0;
    int bad = 0;
    bit model_ok = 1'b0;

    always #5 clk = ~clk;

    btb_branch_predictor dut (
        .Clock(clk),
        .Reset(rst),
        .Flush_All(flush),
        .Lookup_PC(lpc),
        .Pred_Hit(hit),
        .Pred_Taken(taken),
        .Pred_Next_PC(npc),
        .Upd_Valid(uv),
        .Upd_PC(upc),
        .Upd_Taken(ut),
        .Upd_Target(utg)
    );

    typedef struct {
        logic        v;
        logic [31:0] tag;
        logic [31:0] tgt;
        int          c;
    } ent_t;

    ent_t m [8];

    function automatic int idxof(logic [31:0] p);
        return int'((p >> 2) & 32'd7);
    endfunction

    function automatic logic [31:0] tagof(logic [31:0] p);
        return p >> 5;
    endfunction

    // Entry after one resolved branch, from the training rules.
    function automatic ent_t post(ent_t e, logic tk, logic [31:0] tg,
                                  logic [31:0] tgt);
        ent_t r = e;
        if (e.v && e.tag == tg) begin
            if (tk) begin
                r.c = (e.c < 3) ? e.c + 1 : 3;
                r.tgt = tgt;
            end else begin
                r.c = (e.c > 0) ? e.c - 1 : 0;
            end
        end else if (tk) begin
            r.v = 1'b1;
            r.tag = tg;
            r.tgt = tgt;
            r.c = 2;
        end
        return r;
    endfunction

    // Model state advance on each rising edge.
    always @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < 8; i++) begin
                m[i].v <= 1'b0;
                m[i].c <= 0;
            end
            if (rst) model_ok <= 1'b1;
        end else if (uv) begin
            m[idxof(upc)] <= post(m[idxof(upc)], ut, tagof(upc), utg);
        end
    end

    ent_t        ce;
    logic        eh;
    logic        et;
    logic [31:0] en;

    // Per-cycle check of all lookup outputs against the model.
    always @(negedge clk) begin
        if (model_ok && !rst) begin
            ce = m[idxof(lpc)];
`ifdef BTB_BYPASS_EN
            if (uv && !flush && (upc >> 2) == (lpc >> 2))
                ce = post(ce, ut, tagof(upc), utg);
`endif
            eh = ce.v && (ce.tag == tagof(lpc));
            et = eh && (ce.c >= 2);
            en = et ? ce.tgt : lpc + 32'd4;
            total++;
            if (hit !== eh || taken !== et || npc !== en) begin
                bad++;
                $display("FAIL model lpc=%h: got hit=%0b taken=%0b next=%h, want hit=%0b taken=%0b next=%h",
                         lpc, hit, taken, npc, eh, et, en);
            end
        end
    end

    task automatic drive(logic r, logic f, logic v, logic [31:0] p,
                         logic t, logic [31:0] g, logic [31:0] l);
        @(posedge clk);
        #1;
        rst = r;
        flush = f;
        uv = v;
        upc = p;
        ut = t;
        utg = g;
        lpc = l;
    endtask

    task automatic idle(logic [31:0] l);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, l);
    endtask

    task automatic upd(logic [31:0] p, logic t, logic [31:0] g);
        drive(1'b0, 1'b0, 1'b1, p, t, g, 32'h00400000);
    endtask

    task automatic lit(string nm, logic xh, logic xt, logic [31:0] xn);
        @(negedge clk);
        #1;
        total++;
        if (hit !== xh || taken !== xt || npc !== xn) begin
            bad++;
            $display("FAIL %s: got hit=%0b taken=%0b next=%h, want hit=%0b taken=%0b next=%h",
                     nm, hit, taken, npc, xh, xt, xn);
        end
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        idle(32'h00400010);
        lit("t1_reset", 1'b0, 1'b0, 32'h00400014);

        upd(32'h00400010, 1'b1, 32'h00400100);
        idle(32'h00400010);
        lit("t2_alloc", 1'b1, 1'b1, 32'h00400100);

        upd(32'h00400010, 1'b0, 32'h0);
        upd(32'h00400010, 1'b0, 32'h0);
        idle(32'h00400010);
        lit("t3_dec", 1'b1, 1'b0, 32'h00400014);
        upd(32'h00400010, 1'b0, 32'h0);
        idle(32'h00400010);
        lit("t3_floor", 1'b1, 1'b0, 32'h00400014);

        upd(32'h00400010, 1'b1, 32'h00400100);
        upd(32'h00400010, 1'b1, 32'h00400100);
        upd(32'h00400010, 1'b1, 32'h00400100);
        upd(32'h00400010, 1'b1, 32'h00400104);
        upd(32'h00400010, 1'b0, 32'h00400888);
        idle(32'h00400010);
        lit("t3_ceiling", 1'b1, 1'b1, 32'h00400104);

        upd(32'h00400030, 1'b1, 32'h00400300);
        idle(32'h00400010);
        lit("t4_old_tag", 1'b0, 1'b0, 32'h00400014);
        idle(32'h00400030);
        lit("t4_new_tag", 1'b1, 1'b1, 32'h00400300);

        drive(1'b0, 1'b1, 1'b1, 32'h00400050, 1'b1, 32'h00400500,
              32'h00400000);
        idle(32'h00400050);
        lit("t5_dropped", 1'b0, 1'b0, 32'h00400054);
        idle(32'h00400030);
        lit("t5_flushed", 1'b0, 1'b0, 32'h00400034);

        drive(1'b0, 1'b0, 1'b1, 32'h00400020, 1'b1, 32'h00400200,
              32'h00400020);
`ifdef BTB_BYPASS_EN
        lit("t6_same", 1'b1, 1'b1, 32'h00400200);
`else
        lit("t6_same", 1'b0, 1'b0, 32'h00400024);
`endif
        idle(32'h00400020);
        lit("t6_next", 1'b1, 1'b1, 32'h00400200);

        drive(1'b0, 1'b0, 1'b1, 32'h00400000, 1'b1, 32'h00401000,
              32'h00400100);
        drive(1'b0, 1'b0, 1'b1, 32'h00400004, 1'b1, 32'h00401004,
              32'h00400100);
        idle(32'h00400000);
        lit("b2b_idx0", 1'b1, 1'b1, 32'h00401000);
        idle(32'h00400004);
        lit("b2b_idx1", 1'b1, 1'b1, 32'h00401004);

        idle(32'hFFFFFFFC);
        lit("wrap", 1'b0, 1'b0, 32'h00000000);

        drive(1'b1, 1'b0, 1'b1, 32'h00400008, 1'b1, 32'h00400800,
              32'h00400008);
        idle(32'h00400008);
        lit("rst_drop", 1'b0, 1'b0, 32'h0040000C);
        idle(32'h00400020);
        lit("rst_clear", 1'b0, 1'b0, 32'h00400024);

        idle(32'h00400000);
        idle(32'h00400000);
        @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
